sliding_window_frame_ctrl: RTL and testbench

//  Frame-level sequencer in front of the CNN sliding-window line buffer.
//  - Accepts a row-major pixel stream and forwards it to the buffer (buf_push/buf_pixel).
//  - Tracks row/column and applies a runtime stride.
//  - Emits one valid/ready token, with top-left coordinates, per stride-aligned full window.
//  - Stalls the source when the downstream MAC array back-pressures.

---
 rtl/sliding_window_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sliding_window_frame_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sliding_window_frame_ctrl
// Purpose  : Frame sequencer for the CNN line buffer; emits stride-aligned
//            window tokens. Optional SLIDING_WINDOW_CTRL_PERF_EN adds a stall counter.
// Revision : 1.0
// ============================================================================
module sliding_window_frame_ctrl #(
    parameter int WIDTH       = 64,
    parameter int HEIGHT      = 64,
    parameter int PIXEL_WIDTH = 8,
    parameter int WINDOW      = 3,
    parameter int STRIDE_W    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [STRIDE_W-1:0]        cfg_stride,
    output logic                       busy,
    output logic                       done,
    input  logic                       src_valid,
    input  logic [PIXEL_WIDTH-1:0]     src_pixel,
    output logic                       src_ready,
    output logic                       buf_clear,
    output logic                       buf_push,
    output logic [PIXEL_WIDTH-1:0]     buf_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(HEIGHT)-1:0]  out_row,
    output logic [$clog2(WIDTH)-1:0]   out_col,
    output logic                       out_last
`ifdef SLIDING_WINDOW_CTRL_PERF_EN
    ,
    output logic [31:0]                perf_stall_cycles
`endif
);

    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam logic [31:0] c_WIN_M1 = 32'(WINDOW - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [STRIDE_W-1:0]   r_stride;
    logic [STRIDE_W-1:0]   r_row_ph;
    logic [STRIDE_W-1:0]   r_col_ph;
    logic                  r_out_valid;
    logic [RW-1:0]         r_out_row;
    logic [CW-1:0]         r_out_col;
    logic                  r_out_last;

    logic                  w_start_acc;
    logic                  w_push;
    logic                  w_row_ok;
    logic                  w_col_ok;
    logic                  w_qual;
    logic                  w_tok_last;
    logic                  w_col_wrap;
    logic                  w_last_pix;
    logic [RW-1:0]         w_row_nxt;
    logic [CW-1:0]         w_col_nxt;
    logic [STRIDE_W-1:0]   w_row_ph_nxt;
    logic [STRIDE_W-1:0]   w_col_ph_nxt;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign src_ready   = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_push      = src_valid && src_ready;
    assign buf_push    = w_push;
    assign buf_pixel   = src_pixel;
    assign buf_clear   = w_start_acc;
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign out_valid   = r_out_valid;
    assign out_row     = r_out_row;
    assign out_col     = r_out_col;
    assign out_last    = r_out_last;

    assign w_row_ok   = 32'(r_row) >= c_WIN_M1;
    assign w_col_ok   = 32'(r_col) >= c_WIN_M1;
    assign w_qual     = w_push && w_row_ok && w_col_ok && (r_row_ph == '0) && (r_col_ph == '0);
    // Last token when neither axis has room for another stride step.
    assign w_tok_last = (32'(r_col) + 32'(r_stride) >= 32'(WIDTH)) &&
                        (32'(r_row) + 32'(r_stride) >= 32'(HEIGHT));
    assign w_col_wrap = (r_col == CW'(WIDTH - 1));
    assign w_last_pix = w_col_wrap && (r_row == RW'(HEIGHT - 1));
    assign w_col_nxt  = w_col_wrap ? '0 : r_col + 1'b1;
    assign w_row_nxt  = (r_row == RW'(HEIGHT - 1)) ? '0 : r_row + 1'b1;

    // Phase counters restart at the window origin and then cycle modulo stride.
    always_comb begin
        w_col_ph_nxt = r_col_ph;
        if (32'(w_col_nxt) == c_WIN_M1)
            w_col_ph_nxt = '0;
        else if (w_col_ok)
            w_col_ph_nxt = (r_col_ph == r_stride - 1'b1) ? '0 : r_col_ph + 1'b1;
        w_row_ph_nxt = r_row_ph;
        if (32'(w_row_nxt) == c_WIN_M1)
            w_row_ph_nxt = '0;
        else if (w_row_ok)
            w_row_ph_nxt = (r_row_ph == r_stride - 1'b1) ? '0 : r_row_ph + 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_push && w_last_pix) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!r_out_valid || out_ready) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_stride    <= STRIDE_W'(1);
            r_row_ph    <= '0;
            r_col_ph    <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_row    <= '0;
                r_col    <= '0;
                r_row_ph <= '0;
                r_col_ph <= '0;
                r_stride <= (cfg_stride == '0) ? STRIDE_W'(1) : cfg_stride;
            end else if (w_push) begin
                r_col    <= w_col_nxt;
                r_col_ph <= w_col_ph_nxt;
                if (w_col_wrap) begin
                    r_row    <= w_row_nxt;
                    r_row_ph <= w_row_ph_nxt;
                end
            end
            if (w_qual) begin
                r_out_valid <= 1'b1;
                r_out_row   <= RW'(32'(r_row) - c_WIN_M1);
                r_out_col   <= CW'(32'(r_col) - c_WIN_M1);
                r_out_last  <= w_tok_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

`ifdef SLIDING_WINDOW_CTRL_PERF_EN
    logic [31:0] r_perf;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_perf <= '0;
        else if (w_start_acc)
            r_perf <= '0;
        else if ((r_state == S_RUN) && src_valid && !src_ready && (r_perf != 32'hFFFF_FFFF))
            r_perf <= r_perf + 32'd1;
    end
    assign perf_stall_cycles = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sliding_window_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sliding_window_frame_ctrl
// Purpose  : Directed self-checking bench for sliding_window_frame_ctrl (8x8, 3x3).
// Revision : 1.0
// ============================================================================
module tb_sliding_window_frame_ctrl;
    localparam int WIDTH = 8;
    localparam int HEIGHT = 8;
    localparam int PIXEL_WIDTH = 8;
    localparam int WINDOW = 3;
    localparam int STRIDE_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, start, src_valid, out_ready;
    logic [STRIDE_W-1:0]    cfg_stride;
    logic [PIXEL_WIDTH-1:0] src_pixel, buf_pixel;
    logic                   busy, done, src_ready, buf_clear, buf_push, out_valid, out_last;
    logic [2:0]             out_row, out_col;
`ifdef SLIDING_WINDOW_CTRL_PERF_EN
    logic [31:0]            perf_stall_cycles;
`endif

    sliding_window_frame_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_WIDTH(PIXEL_WIDTH),
        .WINDOW(WINDOW), .STRIDE_W(STRIDE_W)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .cfg_stride(cfg_stride),
        .busy(busy), .done(done), .src_valid(src_valid), .src_pixel(src_pixel),
        .src_ready(src_ready), .buf_clear(buf_clear), .buf_push(buf_push),
        .buf_pixel(buf_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
`ifdef SLIDING_WINDOW_CTRL_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         push_cnt, done_cnt, clr_cnt, first_push;
    bit         first_seen;
    logic [6:0] tq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Observe one cycle at the falling edge, then advance to just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (out_valid && !first_seen) begin
            first_seen = 1'b1;
            first_push = push_cnt;
        end
        if (out_valid && out_ready) tq.push_back({out_row, out_col, out_last});
        if (buf_push) begin
            check_eq("buf_pixel", 32'(buf_pixel), 32'(8'(push_cnt)));
            push_cnt++;
        end
        if (done) done_cnt++;
        if (buf_clear) clr_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [2:0] stride, input int stall_len,
                             input int abort_at, input int start_again);
        bit stall_used = 1'b0;
        tq.delete();
        push_cnt = 0; done_cnt = 0; clr_cnt = 0; first_push = 0; first_seen = 1'b0;
        cfg_stride = stride; out_ready = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0; src_valid = 1'b1;
        for (int cyc = 0; cyc < 600 && done_cnt == 0; cyc++) begin
            if (abort_at != 0 && push_cnt == abort_at) begin
                rst = 1'b1;
                #1;
                check_eq("abort_busy", 32'(busy), 0);
                check_eq("abort_valid", 32'(out_valid), 0);
                check_eq("abort_src_ready", 32'(src_ready), 0);
                check_eq("abort_push", 32'(buf_push), 0);
                src_valid = 1'b0;
                cycle(); cycle();
                rst = 1'b0;
                break;
            end
            start = (cyc == start_again);
            if (stall_len > 0 && !stall_used && out_valid) begin
                stall_used = 1'b1;
                out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check_eq("stall_src_ready", 32'(src_ready), 0);
                    check_eq("stall_row", 32'(out_row), 0);
                    check_eq("stall_col", 32'(out_col), 0);
                    check_eq("stall_busy", 32'(busy), 1);
                    if (buf_push) push_cnt++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            src_pixel = 8'(push_cnt);
            cycle();
        end
        src_valid = 1'b0; start = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic check_tokens(input string tag, input int s, input int exp_n);
        logic [6:0] eq[$];
        logic [6:0] t;
        for (int r = 0; r <= 5; r += s)
            for (int c = 0; c <= 5; c += s)
                eq.push_back({3'(r), 3'(c), 1'b0});
        t = eq.pop_back();
        t[0] = 1'b1;
        eq.push_back(t);
        check_eq({tag, "_ntok"}, 32'(tq.size()), 32'(exp_n));
        for (int i = 0; i < tq.size() && i < eq.size(); i++)
            check_eq($sformatf("%s_tok%0d", tag, i), 32'(tq[i]), 32'(eq[i]));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_stride = '0; src_valid = 1'b0;
        src_pixel = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_src_ready", 32'(src_ready), 0);
        check_eq("rst_clear", 32'(buf_clear), 0);
        check_eq("rst_push", 32'(buf_push), 0);
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_row", 32'(out_row), 0);
        check_eq("rst_col", 32'(out_col), 0);
        check_eq("rst_last", 32'(out_last), 0);
`ifdef SLIDING_WINDOW_CTRL_PERF_EN
        check_eq("rst_perf", perf_stall_cycles, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_frame(3'd1, 0, 0, -1);
        check_eq("t1_clear", 32'(clr_cnt), 1);
        check_eq("t1_first_push", 32'(first_push), 19);
        check_eq("t1_pushes", 32'(push_cnt), 64);
        check_eq("t1_done", 32'(done_cnt), 1);
        check_eq("t1_idle", 32'(busy), 0);
        check_tokens("t1", 1, 36);

        run_frame(3'd2, 0, 0, -1);
        check_eq("t2_done", 32'(done_cnt), 1);
        check_eq("t2_pushes", 32'(push_cnt), 64);
        check_tokens("t2", 2, 9);

        run_frame(3'd0, 0, 0, -1);
        check_eq("t2z_done", 32'(done_cnt), 1);
        check_tokens("t2z", 1, 36);

        run_frame(3'd1, 5, 0, -1);
        check_eq("t3_pushes", 32'(push_cnt), 64);
        check_eq("t3_done", 32'(done_cnt), 1);
        check_tokens("t3", 1, 36);

        run_frame(3'd1, 0, 0, 20);
        check_eq("t4_clear", 32'(clr_cnt), 1);
        check_eq("t4_done", 32'(done_cnt), 1);
        check_tokens("t4", 1, 36);

        run_frame(3'd1, 0, 30, -1);
        check_eq("t5_abort_done", 32'(done_cnt), 0);
        check_eq("t5_abort_pushes", 32'(push_cnt), 30);
        run_frame(3'd1, 0, 0, -1);
        check_eq("t5_done", 32'(done_cnt), 1);
        check_eq("t5_first_push", 32'(first_push), 19);
        check_tokens("t5", 1, 36);

`ifdef SLIDING_WINDOW_CTRL_PERF_EN
        run_frame(3'd1, 7, 0, -1);
        check_eq("t6_perf", perf_stall_cycles, 7);
        check_eq("t6_done", 32'(done_cnt), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
